arb_rr_8b: RTL

ARB_RR_8B -- requirements
Module: arb_rr_8b

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_prio_enc8.sv | 20 ++
 rtl/arb_rr_8b.sv | 115 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and widths for the 8-way arbiter
package arb_pkg;
    localparam int N_REQ  = 8;
    localparam int ID_W   = 3;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;
endpackage

// File: rtl/arb_prio_enc8.sv
// rtl/arb_prio_enc8.sv - combinational 8->3 highest-set-bit encoder with valid
module arb_prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = |i_vec;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/arb_rr_8b.sv
// rtl/arb_rr_8b.sv - 8-requester arbiter, fixed or round-robin, with hold timeout
module arb_rr_8b
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mode,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t        r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]   r_gnt_id, w_id_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_timeout, w_timeout_nxt;
    logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;

    logic [N_REQ-1:0]  w_rev;
    logic [N_REQ-1:0]  w_enc_in;
    logic [ID_W-1:0]   w_enc_idx;
    logic              w_enc_valid;
    logic [ID_W-1:0]   w_win;
    logic              w_held;
    logic              w_expire;

    // Rotate right by ptr and bit-reverse, so the highest-bit encoder finds
    // the first request at or above ptr (wrapping).
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rev[N_REQ-1-i] = req[ID_W'(i) + r_ptr];
        end
    end

    assign w_enc_in = mode ? w_rev : req;

    arb_prio_enc8 u_enc (
        .i_vec   (w_enc_in),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    assign w_win    = mode ? (3'd7 - w_enc_idx + r_ptr) : w_enc_idx;
    assign w_held   = req[r_gnt_id];
    assign w_expire = (r_hold == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = '0;
        w_id_nxt      = '0;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        case (r_state)
            IDLE: begin
                if (w_enc_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_id_nxt    = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                w_hold_nxt = (r_hold == '1) ? r_hold : r_hold + HOLD_W'(1);
                if (done || !w_held || w_expire) begin
                    w_state_nxt   = RELEASE;
                    w_ptr_nxt     = r_gnt_id + ID_W'(1);
                    w_timeout_nxt = w_expire && !done && w_held;
                end else begin
                    w_gnt_nxt   = r_gnt;
                    w_id_nxt    = r_gnt_id;
                    w_valid_nxt = 1'b1;
                end
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_ptr     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_id_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;

endmodule
